// File: rtl/dlx_pkg.sv
// Shared DLX core types: next-PC commands used by fetch and decode, fetch
// FSM states and core-wide constants.
package dlx_pkg;

   localparam int          INSTR_W          = 32;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   typedef enum logic [1:0] {
      PC_SEQ    = 2'b00,
      PC_BRANCH = 2'b01,
      PC_JUMP   = 2'b10,
      PC_HALT   = 2'b11
   } pc_cmd_t;

   typedef enum logic [1:0] {
      REQ     = 2'b00,
      ISSUE   = 2'b01,
      RESOLVE = 2'b10,
      HALT    = 2'b11
   } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between fetch and memory.
interface fetch_unit_if #(
   parameter int ADDR_W = 32
);
   import dlx_pkg::*;

   logic [ADDR_W-1:0]  i_address;
   logic               i_read_req;
   logic               i_ack;
   logic [INSTR_W-1:0] i_data_in;

   modport master (
      output i_address,
      output i_read_req,
      input  i_ack,
      input  i_data_in
   );

   modport slave (
      input  i_address,
      input  i_read_req,
      output i_ack,
      output i_data_in
   );

endinterface

// File: rtl/fetch_unit_pc_next.sv
// Next-PC arithmetic: resolves an execute command into a word-aligned
// address, wrapping modulo 2^ADDR_W, and flags the halt command.
module pc_next
   import dlx_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic [ADDR_W-1:0] pc_i,
   input  pc_cmd_t           cmd_i,
   input  logic [ADDR_W-1:0] target_i,
   output logic [ADDR_W-1:0] next_pc_o,
   output logic              halt_o
);

   logic [ADDR_W-1:0] seqPc;
   logic [ADDR_W-1:0] rawPc;

   assign seqPc = pc_i + ADDR_W'(4);

   always_comb begin
      rawPc  = seqPc;
      halt_o = 1'b0;
      unique case (cmd_i)
         PC_SEQ:    rawPc = seqPc;
         PC_BRANCH: rawPc = seqPc + target_i;
         PC_JUMP:   rawPc = target_i;
         PC_HALT: begin
            rawPc  = pc_i;
            halt_o = 1'b1;
         end
      endcase
   end

   // Misaligned targets are silently forced onto a word boundary.
   assign next_pc_o = rawPc & ~ADDR_W'(3);

endmodule

// File: rtl/fetch_unit.sv
// DLX instruction fetch stage: owns the PC, fetches over the memory handshake,
// holds the instruction for decode and waits for execute to pick the next PC.
module fetch_unit
   import dlx_pkg::*;
#(
   parameter int                ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC[ADDR_W-1:0]
) (
   input  logic                clk,
   input  logic                reset_n,
   fetch_unit_if.master        imem,
   output logic [INSTR_W-1:0]  i_data_read,
   output logic                ID,
   input  logic                stall,
   input  logic                Pc_valid,
   input  logic [1:0]          Pc_cmd,
   input  logic [ADDR_W-1:0]   Pc_target,
   output logic [ADDR_W-1:0]   pc,
   output logic [ADDR_W-1:0]   npc
);

   fetch_state_t       state_q, state_d;
   logic [ADDR_W-1:0]  pc_q, pc_d;
   logic [INSTR_W-1:0] ir_q, ir_d;
   logic               req_q, req_d;
   logic               id_q, id_d;
   logic [ADDR_W-1:0]  nextPc;
   logic               haltCmd;

   pc_next #(.ADDR_W(ADDR_W)) u_pc_next (
      .pc_i      (pc_q),
      .cmd_i     (pc_cmd_t'(Pc_cmd)),
      .target_i  (Pc_target),
      .next_pc_o (nextPc),
      .halt_o    (haltCmd)
   );

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= REQ;
         pc_q    <= RESET_PC;
         ir_q    <= '0;
         req_q   <= 1'b0;
         id_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         req_q   <= req_d;
         id_q    <= id_d;
      end
   end

   // An ack only counts once the request is actually on the bus, so a stale
   // ack straddling reset release cannot capture a word.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      unique case (state_q)
         REQ: begin
            if (req_q && imem.i_ack) begin
               ir_d    = imem.i_data_in;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            if (!stall) state_d = RESOLVE;
         end
         RESOLVE: begin
            if (Pc_valid) begin
               if (haltCmd) begin
                  state_d = HALT;
               end else begin
                  pc_d    = nextPc;
                  state_d = REQ;
               end
            end
         end
         HALT: state_d = HALT;
      endcase
      req_d = (state_d == REQ);
      id_d  = (state_d == ISSUE);
   end

   assign imem.i_address    = pc_q;
   assign imem.i_read_req   = req_q;
   assign i_data_read       = ir_q;
   assign ID                = id_q;
   assign pc                = pc_q;
   assign npc               = pc_q + ADDR_W'(4);

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage of the multi-cycle DLX core. It sits directly upstream of the decoder.
- Owns the program counter and drives the instruction-memory request/acknowledge handshake.
- Latches the returned word into an instruction register and presents it to the decoder with a one-cycle ID strobe.
- Waits for execute to resolve the next PC (sequential, relative branch, absolute jump or halt), then fetches again.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0
ADDR_W, 32, PC and instruction address width

Ports:
clk  input  1  core clock, all state on rising edge
reset_n  input  1  synchronous active-low reset
i_address  output  ADDR_W  instruction memory address (word aligned)
i_read_req  output  1  fetch request, held until acknowledged
i_ack  input  1  memory acknowledge; i_data_in valid this cycle
i_data_in  input  32  raw instruction word from memory
i_data_read  output  32  instruction register, feeds decoder
ID  output  1  decode strobe: i_data_read valid for decode
stall  input  1  decoder/execute not ready; extends ID
Pc_valid  input  1  next-PC command valid (from execute)
Pc_cmd  input  2  00 PC+4, 01 PC+4+Pc_target, 10 Pc_target, 11 halt
Pc_target  input  ADDR_W  branch offset (cmd 01) or absolute target (cmd 10)
pc  output  ADDR_W  address of the instruction in i_data_read
npc  output  ADDR_W  pc+4, used for link register

Behaviour:
Reset and outputs
- Reset is synchronous, active-low. While reset_n=0 at the edge: state=REQ, pc=RESET_PC, i_data_read=0, ID=0, i_read_req=0.
- All outputs are registered except npc, which is combinational pc+4.
- i_address always equals pc.

State machine REQ, ISSUE, RESOLVE, HALT:
- REQ: i_read_req=1. On a cycle with i_ack=1: capture i_data_in into i_data_read; next state ISSUE with ID=1 and i_read_req=0. Otherwise stay in REQ with the request held.
- ISSUE: ID=1. If stall=1, stay in ISSUE with ID and i_data_read held stable. If stall=0, next state RESOLVE with ID=0.
- RESOLVE: wait for Pc_valid=1, then compute the new pc:
  - 00: pc+4
  - 01: pc+4+Pc_target
  - 10: Pc_target
  - 11: pc unchanged, next state HALT
  - All other commands: next state REQ.
- HALT: i_read_req=0, ID=0. Only reset exits HALT.

Timing and arithmetic
- Minimum loop is 3 cycles/instruction (ack on the first REQ cycle, no stall, Pc_valid on the first RESOLVE cycle). The first request is visible on the cycle after reset deassertion.
- Arithmetic is modulo 2^ADDR_W: 32'hFFFF_FFFC+4 wraps to 0, and negative offsets wrap naturally.
- New pc bits [1:0] are forced to 0, so misaligned targets are silently aligned.

Ignored inputs
- i_ack outside REQ is ignored; no capture.
- Pc_valid outside RESOLVE is ignored; a pending command is not remembered.
- stall outside ISSUE is ignored.

Reset mid-operation
- Reset during REQ with a request outstanding drops i_read_req at that edge; a late i_ack after reset is ignored unless it coincides with the new REQ.
- Reset wins over i_ack and Pc_valid in the same cycle.

Decomposition:
- Shared package dlx_pkg holds:
  - pc_cmd_t enum (PC_SEQ=2'b00, PC_BRANCH=2'b01, PC_JUMP=2'b10, PC_HALT=2'b11), shared with the decoder's Pc_cmd
  - fetch_state_t enum
  - INSTR_W=32 and the default RESET_PC
- One sub-module, pc_next: combinational (pc, Pc_cmd, Pc_target) -> aligned next pc plus halt flag.

Test Plan:
- Reset then ack on first REQ cycle with i_data_in=32'h2001_0005, no stall, Pc_valid/Pc_cmd=00 -> i_address 0 then 4; ID high exactly one cycle; i_data_read=32'h2001_0005; 3-cycle loop.
- Memory delays ack 4 cycles -> i_read_req held 5 cycles with i_address stable; ID only after ack; word captured only on the ack cycle.
- stall=1 for 3 cycles in ISSUE -> ID held 4 cycles, i_data_read unchanged; Pc_valid pulsed during ISSUE is ignored.
- pc=32'h100, Pc_cmd=01, Pc_target=32'hFFFF_FFF0 -> next i_address 32'hF4. Pc_cmd=10, Pc_target=32'h203 -> i_address 32'h200.
- pc=32'hFFFF_FFFC, Pc_cmd=00 -> i_address wraps to 0. Pc_cmd=11 -> HALT; no further requests despite i_ack/Pc_valid toggling.
- reset_n=0 while in REQ awaiting ack -> i_read_req=0 and pc=RESET_PC next cycle; refetch from RESET_PC after release.
